// File: rtl/cdt_cnt_pkg.sv
// Shared constants and helpers for the CDT counter blocks.
// Provides default widths and the saturated all-ones value for a given counter width.
package cdt_cnt_pkg;

    localparam int CNT_W_DEFAULT = 32;
    localparam int N_CH_MAX      = 32;

    function automatic logic [31:0] sat_value(input int w);
        if (w >= 32)
            return 32'hFFFF_FFFF;
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/lv2_rej_bank_if.sv
// Spill gate, per-channel reject inputs and registered readback port of the reject bank.
// master drives the gate, requests and address; slave is the counter bank.
interface lv2_rej_bank_if #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 32,
    parameter int AW    = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic             in_live;
    logic [N_CH-1:0]  lv1a_req;
    logic [N_CH-1:0]  lv2_buffer_full;
    logic [AW-1:0]    rd_addr;
    logic             rd_snap;
    logic [CNT_W-1:0] rd_data;
    logic             rd_sat;
    logic             snap_valid;
    logic             any_rej;

    modport master (
        output in_live, lv1a_req, lv2_buffer_full, rd_addr, rd_snap,
        input  rd_data, rd_sat, snap_valid, any_rej
    );

    modport slave (
        input  in_live, lv1a_req, lv2_buffer_full, rd_addr, rd_snap,
        output rd_data, rd_sat, snap_valid, any_rej
    );
endinterface

// File: rtl/lv2_rej_ch.sv
// One channel: saturating reject counter with sticky sat flag, plus snapshot latched on spill fall.
// Counter updates at the edge ending the event cycle; no backpressure.
module lv2_rej_ch
    import cdt_cnt_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rise,
    input  logic             fall,
    input  logic             hit,
    output logic [CNT_W-1:0] cnt,
    output logic             sat,
    output logic [CNT_W-1:0] snap,
    output logic             snap_sat
);
    localparam logic [31:0] MAX32 = sat_value(CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = MAX32[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_nxt;
    logic             sat_nxt;

    // A rise clears and counts in the same cycle, so an event there leaves 1.
    always_comb begin
        cnt_nxt = cnt;
        sat_nxt = sat;
        if (rise) begin
            cnt_nxt = {{(CNT_W-1){1'b0}}, hit};
            sat_nxt = 1'b0;
        end else if (hit) begin
            if (cnt == CNT_MAX)
                sat_nxt = 1'b1;
            else
                cnt_nxt = cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            sat      <= 1'b0;
            snap     <= '0;
            snap_sat <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            sat <= sat_nxt;
            // Snapshot takes the post-update value so a fall-cycle event is included.
            if (fall) begin
                snap     <= cnt_nxt;
                snap_sat <= sat_nxt;
            end
        end
    end

endmodule

// File: rtl/lv2_rej_bank.sv
// Level-2 reject counter bank: per-channel saturating counters with spill snapshots and readback.
// Readback latency 1 cycle from address; event-to-readout 2 cycles; no backpressure.
module lv2_rej_bank
    import cdt_cnt_pkg::*;
#(
    parameter int N_CH       = 8,
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter bit COUNT_DEAD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    lv2_rej_bank_if.slave    bus
);
    localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             pre_live;
    logic             rise;
    logic             fall;
    logic             gate;
    logic [N_CH-1:0]  hit;

    logic [CNT_W-1:0] cnt      [N_CH];
    logic [CNT_W-1:0] snap     [N_CH];
    logic [N_CH-1:0]  sat;
    logic [N_CH-1:0]  snap_sat;

    logic [CNT_W-1:0] sel_data;
    logic             sel_sat;

    assign rise = !pre_live && bus.in_live;
    assign fall = pre_live && !bus.in_live;
    assign gate = COUNT_DEAD || bus.in_live;
    assign hit  = bus.lv1a_req & bus.lv2_buffer_full & {N_CH{gate}};

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        lv2_rej_ch #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .rise     (rise),
            .fall     (fall),
            .hit      (hit[g]),
            .cnt      (cnt[g]),
            .sat      (sat[g]),
            .snap     (snap[g]),
            .snap_sat (snap_sat[g])
        );
    end

    // Addresses beyond N_CH match no channel and read back as zero.
    always_comb begin
        sel_data = '0;
        sel_sat  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.rd_addr == AW'(i)) begin
                sel_data = bus.rd_snap ? snap[i] : cnt[i];
                sel_sat  = bus.rd_snap ? snap_sat[i] : sat[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_live       <= 1'b0;
            bus.rd_data    <= '0;
            bus.rd_sat     <= 1'b0;
            bus.snap_valid <= 1'b0;
            bus.any_rej    <= 1'b0;
        end else begin
            pre_live       <= bus.in_live;
            bus.rd_data    <= sel_data;
            bus.rd_sat     <= sel_sat;
            bus.snap_valid <= fall;
            bus.any_rej    <= |hit;
        end
    end

endmodule
